uart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the UART receiver. It captures each received frame (8-bit data plus parity-error and stop-error flags) on the receiver's data-valid indication. It stores frames in a first-word-fall-through FIFO for a slower consumer, and tracks overflow and error statistics. It decouples the bit-rate receiver from the host/register side of the design.

---
 rtl/uart_rx_fifo.sv | 83 ++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected frame capture into a first-word-fall-through
// buffer, with sticky overflow and a saturating errored-frame counter.
module uart_rx_fifo #(
  parameter int DEPTH    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               P_DATA,
  input  logic                     par_err,
  input  logic                     stp_err,
  input  logic                     data_valid,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [7:0]               rd_data,
  output logic                     rd_par_err,
  output logic                     rd_stp_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          dv_q;
  logic          push;
  logic          err;
  logic          drop;
  logic          pop;
  logic          wr;
  logic          ovf_set;

  assign push    = data_valid & ~dv_q;
  assign err     = par_err | stp_err;
  assign drop    = DROP_ERR & err;
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign wr      = push & ~drop & (~full | pop);
  assign ovf_set = push & ~drop & full & ~pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign {rd_stp_err, rd_par_err, rd_data} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      dv_q <= data_valid;
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (push && err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {stp_err, par_err, P_DATA};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one keep-errors and one drop-errors
// instance share stimulus and are checked against queue-based models.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       par_err;
  logic       stp_err;
  logic       data_valid;
  logic       rd_en;
  logic       ovf_clr;

  logic [7:0] rd_data [2];
  logic       rd_pe   [2];
  logic       rd_se   [2];
  logic       emp     [2];
  logic       ful     [2];
  logic [3:0] cnt     [2];
  logic       ovf     [2];
  logic [7:0] ecnt    [2];

  int total = 0;
  int bad   = 0;

  logic [9:0] q [2][$];
  int         m_err [2];
  bit         m_ovf [2];
  bit         mpop  [2];
  bit         dvp;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .par_err(par_err),
    .stp_err(stp_err), .data_valid(data_valid), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(rd_data[0]), .rd_par_err(rd_pe[0]),
    .rd_stp_err(rd_se[0]), .empty(emp[0]), .full(ful[0]),
    .count(cnt[0]), .overflow(ovf[0]), .err_cnt(ecnt[0])
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .par_err(par_err),
    .stp_err(stp_err), .data_valid(data_valid), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(rd_data[1]), .rd_par_err(rd_pe[1]),
    .rd_stp_err(rd_se[1]), .empty(emp[1]), .full(ful[1]),
    .count(cnt[1]), .overflow(ovf[1]), .err_cnt(ecnt[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: status every cycle, head entry whenever the consumer pops
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [9:0] e;
        chk($sformatf("count%0d", k), int'(cnt[k]), q[k].size());
        chk($sformatf("empty%0d", k), int'(emp[k]), int'(q[k].size() == 0));
        chk($sformatf("full%0d", k), int'(ful[k]), int'(q[k].size() == DEPTH));
        chk($sformatf("overflow%0d", k), int'(ovf[k]), int'(m_ovf[k]));
        chk($sformatf("err_cnt%0d", k), int'(ecnt[k]), m_err[k]);
        mpop[k] = 1'b0;
        if (rd_en && q[k].size() > 0) begin
          e = q[k].pop_front();
          mpop[k] = 1'b1;
          chk($sformatf("rd_data%0d", k), int'(rd_data[k]), int'(e[7:0]));
          chk($sformatf("rd_par_err%0d", k), int'(rd_pe[k]), int'(e[8]));
          chk($sformatf("rd_stp_err%0d", k), int'(rd_se[k]), int'(e[9]));
        end
      end
    end
  end

  // Drive one cycle of inputs, then advance the model at the clock edge
  task automatic step(input bit dv, input logic [7:0] d, input bit pe,
                      input bit se, input bit rd, input bit clr);
    data_valid = dv;
    P_DATA     = d;
    par_err    = pe;
    stp_err    = se;
    rd_en      = rd;
    ovf_clr    = clr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit push, er, drop, oset;
      int occ;
      push = dv && !dvp;
      er   = pe || se;
      drop = (k == 1) && er;
      occ  = q[k].size() + int'(mpop[k]);
      oset = 1'b0;
      if (push && er && m_err[k] < 255)
        m_err[k]++;
      if (push && !drop) begin
        if (occ < DEPTH || mpop[k])
          q[k].push_back({se, pe, d});
        else
          oset = 1'b1;
      end
      m_ovf[k] = oset || (m_ovf[k] && !clr);
      mpop[k]  = 1'b0;
    end
    dvp = dv;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [7:0] d, input bit pe, input bit se,
                       input bit rd);
    step(1'b1, d, pe, se, rd, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, rd, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      m_err[k] = 0;
      m_ovf[k] = 1'b0;
      mpop[k]  = 1'b0;
    end
    dvp = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset(input bit dv_hold);
    rst = 1'b1;
    data_valid = dv_hold;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_count%0d", k), int'(cnt[k]), 0);
      chk($sformatf("rst_empty%0d", k), int'(emp[k]), 1);
      chk($sformatf("rst_full%0d", k), int'(ful[k]), 0);
      chk($sformatf("rst_overflow%0d", k), int'(ovf[k]), 0);
      chk($sformatf("rst_err_cnt%0d", k), int'(ecnt[k]), 0);
    end
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    P_DATA = '0; par_err = 0; stp_err = 0;
    data_valid = 0; rd_en = 0; ovf_clr = 0;
    clear_model();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_count%0d", k), int'(cnt[k]), 0);
      chk($sformatf("init_empty%0d", k), int'(emp[k]), 1);
      chk($sformatf("init_overflow%0d", k), int'(ovf[k]), 0);
      chk($sformatf("init_err_cnt%0d", k), int'(ecnt[k]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic order
    pulse(8'h11, 0, 0, 0);
    pulse(8'h22, 0, 0, 0);
    pulse(8'h33, 0, 0, 0);
    chk("basic_count", int'(cnt[0]), 3);
    drain();

    // Level hold gives one push
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'hA5, 0, 0, 0, 0);
    idle(1);
    chk("level_count", int'(cnt[0]), 1);
    drain();

    // Fill past full, clear overflow, push+pop while full
    for (int i = 0; i < 9; i++)
      pulse(8'(i), 0, 0, 0);
    chk("ovf_full", int'(ful[0]), 1);
    chk("ovf_flag", int'(ovf[0]), 1);
    step(1'b0, 8'h00, 0, 0, 0, 1'b1);
    chk("ovf_clr", int'(ovf[0]), 0);
    pulse(8'h40, 0, 0, 1);
    drain();

    // Error tagging in both modes
    pulse(8'h5A, 1, 0, 0);
    chk("perr_head", int'(rd_pe[0]), 1);
    chk("perr_drop_empty", int'(emp[1]), 1);
    drain();
    pulse(8'h5A, 0, 1, 0);
    drain();
    for (int i = 0; i < 300; i++)
      pulse(8'($urandom), 1'($urandom), 1'b1, 1'($urandom));
    chk("err_sat0", int'(ecnt[0]), 255);
    chk("err_sat1", int'(ecnt[1]), 255);
    step(1'b0, 8'h00, 0, 0, 0, 1'b1);
    drain();

    // Interleaved push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      pulse(8'($urandom), 0, 0, 0);
      step(1'b0, 8'h00, 0, 0, 1'b1, 0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) != 0), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    step(1'b0, 8'h00, 0, 0, 0, 1'b1);
    drain();

    // Corner cases on an empty FIFO
    step(1'b0, 8'h00, 0, 0, 1'b1, 0);
    step(1'b0, 8'h00, 0, 0, 1'b1, 0);
    chk("rd_empty_count", int'(cnt[0]), 0);
    step(1'b1, 8'hC3, 0, 0, 1'b1, 0);
    idle(1);
    chk("push_rd_empty_count", int'(cnt[0]), 1);
    drain();

    // Reset mid-stream with count=5 and overflow set
    for (int i = 0; i < 9; i++)
      pulse(8'(8'h80 + i), 1'(i == 2), 0, 0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h00, 0, 0, 1'b1, 0);
    chk("pre_rst_count", int'(cnt[0]), 5);
    chk("pre_rst_ovf", int'(ovf[0]), 1);
    do_reset(1'b0);
    idle(2);

    // data_valid high across reset release pushes once
    pulse(8'h01, 0, 0, 0);
    do_reset(1'b1);
    step(1'b1, 8'h77, 0, 0, 0, 0);
    step(1'b1, 8'h78, 0, 0, 0, 0);
    idle(1);
    chk("dv_at_release", int'(cnt[0]), 1);
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
